// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic/shift ops, and a WIDTH-cycle shift-add MUL.
// Valid/ready: a request transfers on a rising edge with in_valid && in_ready; a result transfers on a rising edge with out_valid && out_ready.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic [1:0]       dbg_state_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic [3:0]           flags_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH:0]       mul_sum;

  logic [WIDTH:0]       add_ext;
  logic [WIDTH:0]       shl_ext;
  logic [WIDTH:0]       shr_ext;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic [SW-1:0]        sh_amt;

  // Single-cycle datapath, evaluated on the live inputs and registered at the accept edge.
  always_comb begin
    add_ext = '0;
    shl_ext = '0;
    shr_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sh_amt  = b[SW-1:0];
    case (ALUControl)
      OP_ADD: begin
        add_ext = {1'b0, a} + {1'b0, b};
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        add_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_LSL: begin
        // The guard bit above/below the operand catches the last bit shifted out.
        shl_ext = {1'b0, a} << sh_amt;
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_LSR: begin
        shr_ext = {a, 1'b0} >> sh_amt;
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // One shift-add step: add the multiplicand into the high half when the multiplier LSB is set,
  // then shift the whole {carry, high, low} product right by one.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (ALUControl == OP_MUL) begin
              mcand_q <= a;
              prod_q  <= {{WIDTH{1'b0}}, b};
              cnt_q   <= '0;
              state_q <= ST_MUL;
            end else begin
              result_q    <= alu_res;
              flags_q     <= {alu_res[WIDTH-1], ~|alu_res, alu_c, alu_v};
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          prod_q <= prod_d;
          if (cnt_q == LAST_ITER) begin
            result_q    <= prod_d[WIDTH-1:0];
            flags_q     <= {prod_d[WIDTH-1], ~|prod_d[WIDTH-1:0], |prod_d[2*WIDTH-1:WIDTH], 1'b0};
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign Result      = result_q;
  assign ALUFlags    = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus random bench for seq_alu (WIDTH=32): scoreboard queue of expected {Result, ALUFlags}.
module tb_seq_alu;

  localparam int W = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic [3:0]   ALUFlags;
  logic [1:0]   dbg_state;

  logic [W+3:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .ALUFlags   (ALUFlags),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0]   r;
    logic           c;
    logic           v;
    logic [2*W-1:0] p;
    int             sh;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sh = int'(bv[4:0]);
    case (op)
      3'b000: begin
        p = 64'(av) + 64'(bv);
        r = p[W-1:0];
        c = p[W];
        v = (av[W-1] & bv[W-1] & ~r[W-1]) | (~av[W-1] & ~bv[W-1] & r[W-1]);
      end
      3'b001: begin
        r = av - bv;
        c = (av >= bv);
        v = (av[W-1] ^ bv[W-1]) & (av[W-1] ^ r[W-1]);
      end
      3'b010: r = av & bv;
      3'b011: r = av | bv;
      3'b100: r = av ^ bv;
      3'b101: begin
        r = av << sh;
        c = (sh == 0) ? 1'b0 : av[W-sh];
      end
      3'b110: begin
        r = av >> sh;
        c = (sh == 0) ? 1'b0 : av[sh-1];
      end
      default: begin
        p = 64'(av) * 64'(bv);
        r = p[W-1:0];
        c = (p[2*W-1:W] != 0);
      end
    endcase
    return {r, r[W-1], (r == 0), c, v};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("send_in_ready", in_ready, 1);
    ALUControl = op;
    a          = av;
    b          = bv;
    in_valid   = 1'b1;
    exp_q.push_back(model(op, av, bv));
    @(posedge clk);
    #1;
    // Scramble the inputs after acceptance; the captured operands must be used.
    in_valid   = 1'b0;
    a          = $urandom;
    b          = $urandom;
    ALUControl = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_result(input logic [2:0] op);
    int lows;
    int busy_ready;
    logic [W+3:0] e;
    lows       = 0;
    busy_ready = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lows > 100) break;
      if (in_ready) busy_ready++;
      lows++;
    end
    check("out_valid_seen", out_valid, 1);
    check("latency_low_cycles", lows, (op == OP_MUL) ? W : 0);
    check("in_ready_low_while_busy", busy_ready, 0);
    check("sb_not_empty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_result", Result, e[W+3:4]);
      check("sb_flags", ALUFlags, e[3:0]);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    send(op, av, bv);
    wait_result(op);
    release_result();
  endtask

  // ---------------- directed sequence ----------------
  logic [W-1:0] held_res;
  logic [3:0]   held_flags;
  logic [2:0]   rop;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    ALUControl = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_flags", ALUFlags, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD wrap to zero with carry
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_result(OP_ADD);
    check("add_result", Result, 32'h0000_0000);
    check("add_flags", ALUFlags, 4'b0110);
    release_result();

    // SUB signed overflow, no borrow
    send(OP_SUB, 32'h8000_0000, 32'h0000_0001);
    wait_result(OP_SUB);
    check("sub_result", Result, 32'h7FFF_FFFF);
    check("sub_flags", ALUFlags, 4'b0011);
    release_result();

    // MUL with product overflowing into the high half
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    wait_result(OP_MUL);
    check("mul_ovf_result", Result, 32'h0000_0000);
    check("mul_ovf_flags", ALUFlags, 4'b0110);
    release_result();

    send(OP_MUL, 32'd7, 32'd6);
    wait_result(OP_MUL);
    check("mul_7x6_result", Result, 32'h0000_002A);
    check("mul_7x6_flags", ALUFlags, 4'b0000);
    release_result();

    // LSR using only the low shift bits, then backpressure in DONE
    send(OP_LSR, 32'h8000_0001, 32'h0000_0021);
    wait_result(OP_LSR);
    check("lsr_result", Result, 32'h4000_0000);
    check("lsr_flags", ALUFlags, 4'b0010);
    held_res   = Result;
    held_flags = ALUFlags;
    in_valid   = 1'b1;
    ALUControl = OP_ADD;
    a          = 32'h1234_5678;
    b          = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", Result, held_res);
      check("hold_flags", ALUFlags, held_flags);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    release_result();
    repeat (2) @(negedge clk);
    check("no_capture_out_valid", out_valid, 0);
    check("no_capture_in_ready", in_ready, 1);
    check("no_capture_result", Result, held_res);
    @(posedge clk);
    #1;

    // Shift boundaries
    run_op(OP_LSL, 32'h8000_0001, 32'h0000_0001);
    run_op(OP_LSL, 32'h1234_5678, 32'hFFFF_FFE0);
    run_op(OP_LSL, 32'h0000_0003, 32'h0000_001F);
    run_op(OP_LSR, 32'hF000_000F, 32'h0000_0000);
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op(OP_SUB, 32'h0000_0001, 32'h0000_0002);
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op(rop, ra, rb);
    end

    // Reset in the 10th cycle of a MUL
    send(OP_MUL, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", Result, 0);
    check("mid_rst_flags", ALUFlags, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", out_valid, 0);
    send(OP_ADD, 32'd2, 32'd3);
    wait_result(OP_ADD);
    check("post_rst_add_result", Result, 32'h0000_0005);
    check("post_rst_add_flags", ALUFlags, 4'b0000);
    release_result();
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
